// File: rtl/fifo_sync_pkt.sv
// Packet-aware synchronous FIFO: beats stay speculative until wr_last commits them; aborts roll back.
// Optional build macro FIFO_PKT_OVERSIZE_DROP_EN: drop packets that can never fit instead of stalling.
module fifo_sync_pkt #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_last,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic                  wr_abort,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    input  logic [ADDR_WIDTH:0]   af_thresh,
    input  logic [ADDR_WIDTH:0]   ae_thresh,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic [ADDR_WIDTH:0]   free,
    output logic                  overflow
);
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

`ifdef FIFO_PKT_OVERSIZE_DROP_EN
    typedef enum logic [1:0] {S_IDLE, S_IN_PKT, S_DROP} wr_state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_IN_PKT} wr_state_t;
`endif

    wr_state_t             state;
    logic [ADDR_WIDTH:0]   wr_ptr, wr_commit, rd_ptr;
    logic [ADDR_WIDTH:0]   used;
    logic                  in_drop, oversize, wr_en, fetch;
    logic [DATA_WIDTH:0]   mem [DEPTH];

`ifdef FIFO_PKT_OVERSIZE_DROP_EN
    logic ovf_q;
    assign in_drop  = (state == S_DROP);
    // Nothing committed yet the RAM is full: this packet is larger than DEPTH.
    assign oversize = (state == S_IN_PKT) && full && (wr_commit == rd_ptr);
    assign overflow = ovf_q;
`else
    assign in_drop  = 1'b0;
    assign oversize = 1'b0;
    assign overflow = 1'b0;
`endif

    always_comb begin
        used         = wr_ptr - rd_ptr;
        free         = DEPTH_W - used;
        full         = (free == '0);
        count        = wr_commit - rd_ptr;
        empty        = (count == '0) && !rd_valid;
        almost_full  = (used >= (DEPTH_W - af_thresh));
        almost_empty = (count <= ae_thresh);
        wr_ready     = in_drop || !full;
        wr_en        = wr_valid && wr_ready && !in_drop && !wr_abort && !oversize && !clear;
        fetch        = (rd_ptr != wr_commit) && (!rd_valid || rd_ready);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            wr_ptr    <= '0;
            wr_commit <= '0;
            rd_ptr    <= '0;
            rd_valid  <= 1'b0;
        end else if (clear) begin
            state     <= S_IDLE;
            wr_ptr    <= '0;
            wr_commit <= '0;
            rd_ptr    <= '0;
            rd_valid  <= 1'b0;
        end else begin
            if (fetch) begin
                rd_ptr   <= rd_ptr + 1'b1;
                rd_valid <= 1'b1;
            end else if (rd_valid && rd_ready) begin
                rd_valid <= 1'b0;
            end

            // Abort beats everything, including a last beat offered in the same cycle.
            if (wr_abort) begin
                wr_ptr <= wr_commit;
                state  <= S_IDLE;
`ifdef FIFO_PKT_OVERSIZE_DROP_EN
            end else if (oversize) begin
                wr_ptr <= wr_commit;
                state  <= S_DROP;
            end else if (in_drop) begin
                if (wr_valid && wr_last)
                    state <= S_IDLE;
`endif
            end else if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (wr_last) begin
                    wr_commit <= wr_ptr + 1'b1;
                    state     <= S_IDLE;
                end else begin
                    state     <= S_IN_PKT;
                end
            end
        end
    end

`ifdef FIFO_PKT_OVERSIZE_DROP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf_q <= 1'b0;
        else if (clear)
            ovf_q <= 1'b0;
        else if (!wr_abort && oversize)
            ovf_q <= 1'b1;
    end
`endif

    // RAM and output register carry no reset so they map onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= {wr_last, wr_data};
        if (fetch && !clear)
            {rd_last, rd_data} <= mem[rd_ptr[ADDR_WIDTH-1:0]];
    end

endmodule
